// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered on accept; the result is registered and held under valid/ready.
module alu_req_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_carry,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       rr_q;
  logic       grant_id_c;
  logic       accept_c;

  // Grant: lone valid requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_id_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_c = ~rr_q;
    end else if (req1_valid) begin
      grant_id_c = 1'b1;
    end
    accept_c = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = accept_c && !grant_id_c;
  assign req1_ready = accept_c && grant_id_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, result capture and consumption bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b1;
      alu_ctrl  <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            alu_ctrl <= grant_id_c ? req1_ctrl : req0_ctrl;
            alu_x    <= grant_id_c ? req1_x : req0_x;
            alu_y    <= grant_id_c ? req1_y : req0_y;
            rsp_id   <= grant_id_c;
            rr_q     <= grant_id_c;
          end
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_carry <= alu_carry;
          rsp_valid <= 1'b1;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter with a small behavioural ALU.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_ctrl, req1_ctrl;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [7:0] rsp_out;
  logic [15:0] op_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  alu_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_x(req1_x), .req1_y(req1_y),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry), .op_count(op_count)
  );

  // Combinational ALU stand-in: 0 add, 1 sub, 2 and, 3 or, 4 xor.
  always_comb begin
    {alu_carry, alu_out} = 9'h000;
    case (alu_ctrl)
      4'h0: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
      4'h1: {alu_carry, alu_out} = {1'b0, alu_x} - {1'b0, alu_y};
      4'h2: alu_out = alu_x & alu_y;
      4'h3: alu_out = alu_x | alu_y;
      4'h4: alu_out = alu_x ^ alu_y;
      default: {alu_carry, alu_out} = 9'h000;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete op from requester r, entered just after a falling edge.
  task automatic run_op(input logic r, input logic [3:0] c, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] eo, input logic ec);
    if (r) begin
      req1_ctrl = c; req1_x = x; req1_y = y; req1_valid = 1'b1;
    end else begin
      req0_ctrl = c; req0_x = x; req0_y = y; req0_valid = 1'b1;
    end
    #1;
    chk("op_ready_req", {31'd0, r ? req1_ready : req0_ready}, 32'd1);
    chk("op_ready_other", {31'd0, r ? req0_ready : req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    // Operands scrambled after accept must not reach the result.
    if (r) begin
      req1_x = ~x; req1_y = x; req1_valid = 1'b0;
    end else begin
      req0_x = ~x; req0_y = x; req0_valid = 1'b0;
    end
    #1;
    chk("op_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("op_rsp_out", {24'd0, rsp_out}, {24'd0, eo});
    chk("op_rsp_carry", {31'd0, rsp_carry}, {31'd0, ec});
    chk("op_rsp_id", {31'd0, rsp_id}, {31'd0, r});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("op_rsp_done", {31'd0, rsp_valid}, 32'd0);
    chk("op_count", {16'd0, op_count}, 32'(exp_cnt & 32'hFFFF));
  endtask

  initial begin
    logic [1:0] exp_ids [4];
    int nrsp;

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_ctrl = 4'h0; req0_x = 8'h00; req0_y = 8'h00;
    req1_ctrl = 4'h0; req1_x = 8'h00; req1_y = 8'h00;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_x", {24'd0, alu_x}, 32'd0);
    chk("rst_rsp_out", {24'd0, rsp_out}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    req0_valid = 1'b0;

    // 1: basic add from requester 0.
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 4'h0, 8'h96, 8'h2D, 8'hC3, 1'b0);
    chk("t1_alu_x_held", {24'd0, alu_x}, 32'h96);

    // 2: both valid from reset, responses taken immediately.
    @(negedge clk);
    rst_n = 1'b0;
    exp_cnt = 0;
    req0_ctrl = 4'h0; req0_x = 8'h01; req0_y = 8'h02; req0_valid = 1'b1;
    req1_ctrl = 4'h0; req1_x = 8'h10; req1_y = 8'h20; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd0; exp_ids[3] = 2'd1;
    nrsp = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("t2_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (rsp_valid) begin
        if (nrsp < 4) begin
          chk("t2_rsp_id", {31'd0, rsp_id}, {30'd0, exp_ids[nrsp]});
          chk("t2_rsp_out", {24'd0, rsp_out}, rsp_id ? 32'h30 : 32'h03);
        end
        nrsp++;
      end
      @(negedge clk);
    end
    chk("t2_rsp_total", 32'(nrsp), 32'd4);
    exp_cnt = 4;
    chk("t2_op_count", {16'd0, op_count}, 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

    // 3: response held for 5 cycles with rsp_ready low; req1 waits meanwhile.
    req0_ctrl = 4'h0; req0_x = 8'hFF; req0_y = 8'h01; req0_valid = 1'b1;
    #1;
    chk("t3_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t3_hold_out", {24'd0, rsp_out}, 32'h00);
      chk("t3_hold_carry", {31'd0, rsp_carry}, 32'd1);
      chk("t3_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("t3_count_hold", {16'd0, op_count}, 32'd4);
      @(negedge clk);
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = 5;
    #1;
    chk("t3_rsp_done", {31'd0, rsp_valid}, 32'd0);
    chk("t3_op_count", {16'd0, op_count}, 32'd5);

    // 4: only requester 1 active.
    run_op(1'b1, 4'h0, 8'h05, 8'h07, 8'h0C, 1'b0);
    run_op(1'b1, 4'h0, 8'h80, 8'h80, 8'h00, 1'b1);
    run_op(1'b1, 4'h4, 8'h33, 8'h44, 8'h77, 1'b0);

    // 5a: reset during EXEC.
    @(negedge clk);
    req0_ctrl = 4'h0; req0_x = 8'h11; req0_y = 8'h22; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_exec_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_exec_rst_alu_x", {24'd0, alu_x}, 32'd0);
    chk("t5_exec_rst_count", {16'd0, op_count}, 32'd0);
    exp_cnt = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_x = 8'h40; req1_y = 8'h02;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_tie_req0", {30'd0, req1_ready, req0_ready}, 32'd1);
    // 5b: run to HOLD and reset there.
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_hold_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t5_hold_out", {24'd0, rsp_out}, 32'h33);
    rst_n = 1'b0;
    #1;
    chk("t5_hold_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_hold_rst_out", {24'd0, rsp_out}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5_rst_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_tie_req0_again", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 6: counter wrap.
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(posedge clk);
    release dut.op_count;
    @(negedge clk);
    #1;
    chk("t6_preset", {16'd0, op_count}, 32'hFFFF);
    exp_cnt = 32'hFFFF;
    run_op(1'b0, 4'h1, 8'h10, 8'h01, 8'h0F, 1'b0);
    chk("t6_wrap", {16'd0, op_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
